boot_loader: RTL and testbench
==============================

Name: boot_loader

Overview:
Boot sequencer and RAM bus owner for the 8-bit CPU system. It holds the CPU in reset while a framed byte stream is written into the single-port RAM, then verifies a checksum. On success it hands the RAM bus to the CPU and releases CPU reset. This replaces simulation-only memory preloading, so programs such as fib can be loaded in hardware.

Parameters:
ADDR_W, 16, RAM/CPU address width
BASE_ADDR, 16'h0000, RAM address of first payload byte
MEM_SIZE, 65536, RAM depth in bytes; payload must fit in [BASE_ADDR, MEM_SIZE)
RST_HOLD, 4, cycles cpu_rst stays high after a successful load (range 1..255)

Ports:
clk  in  1  system clock, shared with CPU and RAM
rst  in  1  asynchronous, active-high reset
ld_data  in  8  loader stream byte
ld_valid  in  1  ld_data valid
ld_ready  out  1  loader accepts a byte (registered)
reload  in  1  single-cycle pulse; restarts the load from RUN or FAIL
cpu_addr  in  ADDR_W  CPU bus address
cpu_do  in  8  CPU write data
cpu_we  in  1  CPU write enable
ram_addr  out  ADDR_W  RAM address
ram_di  out  8  RAM write data
ram_we  out  1  RAM write enable
cpu_rst  out  1  reset to CPU (registered)
busy  out  1  load in progress
done  out  1  CPU running
err  out  1  load failed (sticky until reload or rst)

Behaviour:
- Reset values: state IDLE, ld_ready=0, cpu_rst=1, busy=1, done=0, err=0, byte count=0, checksum=0.
- RAM read data is wired directly from RAM do to CPU di outside this block.
- Accept condition: acc = ld_valid & ld_ready. Bytes are consumed only on acc. ld_valid gaps are legal.
- Frame format: LEN_HI, LEN_LO (16-bit length N, big-endian), N payload bytes, then one CSUM byte. CSUM equals the sum of the payload mod 256.
- FSM:
  - IDLE: ld_ready=0. Next cycle goes to LEN_HI and ld_ready becomes 1.
  - LEN_HI: on acc, latch the high length byte.
  - LEN_LO: on acc, form N.
    - If N > MEM_SIZE-BASE_ADDR, go to FAIL.
    - Else if N==0, go to CSUM.
    - Else go to LOAD.
  - LOAD: on acc, ram_we=1 combinationally in the same cycle, ram_addr=BASE_ADDR+count, ram_di=ld_data. Then count++ and sum+=ld_data (8-bit wrap). When count reaches N-1 and acc, go to CSUM.
  - CSUM: on acc, go to RELEASE if ld_data==sum, else go to FAIL.
  - RELEASE: ld_ready=0, cpu_rst=1, ram_we=0. Hold RST_HOLD cycles, then go to RUN.
  - RUN: cpu_rst=0, busy=0, done=1, ld_ready=0. ram_addr=cpu_addr, ram_di=cpu_do, ram_we=cpu_we (pure mux).
  - FAIL: err=1, busy=0, cpu_rst=1, ld_ready=0, ram_we=0.
- Registered outputs change on the clock edge that enters the state.
- Outside RUN, cpu_we is ignored. Outside LOAD-with-acc, ram_we=0 except in RUN.
- reload: honoured only in RUN or FAIL. Next cycle enters LEN_HI with cpu_rst=1, err=0, done=0, count=0, sum=0. Ignored in all other states.
- Address arithmetic is ADDR_W bits. The length check guarantees no wrap.
- rst asserted mid-load: immediate return to reset values. RAM contents already written are left as-is.

Decomposition:
- Shared package boot_pkg holds:
  - state encoding localparams: IDLE, LEN_HI, LEN_LO, LOAD, CSUM, RELEASE, RUN, FAIL
  - frame header length (2) and checksum width (8)
- Natural sub-module: boot_bus_mux, the combinational RAM bus select between loader and CPU, steered by state==RUN.
- FSM, counters and checksum stay in boot_loader.

Test Plan:
1. Stream 00 03 AA BB CC 31 with continuous ld_valid:
   - RAM[0..2]=AA,BB,CC.
   - cpu_rst falls exactly RST_HOLD(4) cycles after the CSUM accept; done=1, err=0.
2. Same frame with 1-cycle ld_valid gaps between every byte:
   - Identical RAM contents.
   - No ram_we pulse in any gap cycle.
3. Frame 00 02 10 20 00 (bad CSUM, expected 30):
   - err=1, cpu_rst stays 1, ld_ready=0.
   - CPU writes are not forwarded to RAM.
4. MEM_SIZE=256, BASE_ADDR=0, header 01 01:
   - FAIL entered after LEN_LO; no RAM write.
   - reload pulse returns to LEN_HI with err=0.
5. Successful load, then in RUN the CPU writes 8'd55 to address 100:
   - RAM[100]=55.
   - reload drives cpu_rst=1 on the next cycle; a new frame 00 01 07 07 writes RAM[0]=07.
6. Assert rst after 2 payload bytes of a 5-byte frame:
   - All outputs return to reset values asynchronously.
   - A fresh full frame afterwards loads correctly.

Source files
------------

// File: rtl/boot_pkg.sv
// Shared types and constants for the boot loader and its RAM bus mux.
package boot_pkg;

  // Loader sequencing states; RUN is the only state where the CPU owns the RAM bus.
  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    LOAD,
    CSUM,
    RELEASE,
    RUN,
    FAIL
  } boot_state_e;

  // Frame header is a big-endian 16-bit length.
  localparam int HDR_LEN = 2;

  // Checksum is the 8-bit wrapping sum of the payload bytes.
  localparam int CSUM_W = 8;

endpackage

// File: rtl/boot_bus_mux.sv
// Combinational RAM bus select: the loader drives the RAM until the CPU is running.
module boot_bus_mux #(
  parameter int ADDR_W = 16
) (
  input  logic              run_sel,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [7:0]        ld_di,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_do,
  input  logic              cpu_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_di,
  output logic              ram_we
);

  // Pure select; CPU writes are dropped whenever the CPU does not own the bus.
  always_comb begin
    ram_addr = ld_addr;
    ram_di   = ld_di;
    ram_we   = ld_we;
    if (run_sel) begin
      ram_addr = cpu_addr;
      ram_di   = cpu_do;
      ram_we   = cpu_we;
    end
  end

endmodule

// File: rtl/boot_loader.sv
// Boot sequencer: loads a framed byte stream into RAM, verifies its checksum,
// then releases the CPU from reset and hands it the RAM bus.
module boot_loader
  import boot_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int unsigned       MEM_SIZE  = 65536,
  parameter int unsigned       RST_HOLD  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        ld_data,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic              reload,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_do,
  input  logic              cpu_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_di,
  output logic              ram_we,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output logic              err
);

  // Bytes of RAM available for a payload starting at BASE_ADDR.
  localparam int unsigned AVAIL = MEM_SIZE - 32'(BASE_ADDR);

  boot_state_e       state_q, state_d;
  logic              ld_ready_q, ld_ready_d;
  logic              cpu_rst_q, cpu_rst_d;
  logic [7:0]        len_hi_q, len_hi_d;
  logic [15:0]       len_q, len_d;
  logic [15:0]       count_q, count_d;
  logic [CSUM_W-1:0] sum_q, sum_d;
  logic [7:0]        hold_q, hold_d;

  logic              acc;
  logic [15:0]       frame_len;
  logic              ld_we;
  logic [ADDR_W-1:0] ld_addr;

  assign acc       = ld_valid & ld_ready_q;
  assign frame_len = {len_hi_q, ld_data};
  assign ld_we     = (state_q == LOAD) & acc;
  assign ld_addr   = BASE_ADDR + ADDR_W'(count_q);

  assign ld_ready = ld_ready_q;
  assign cpu_rst  = cpu_rst_q;
  assign busy     = (state_q != RUN) && (state_q != FAIL);
  assign done     = (state_q == RUN);
  assign err      = (state_q == FAIL);

  // Next-state logic, frame parsing, payload counting and checksum accumulation.
  always_comb begin
    state_d  = state_q;
    len_hi_d = len_hi_q;
    len_d    = len_q;
    count_d  = count_q;
    sum_d    = sum_q;
    hold_d   = hold_q;
    unique case (state_q)
      IDLE: begin
        state_d = LEN_HI;
        count_d = '0;
        sum_d   = '0;
      end
      LEN_HI: begin
        if (acc) begin
          len_hi_d = ld_data;
          state_d  = LEN_LO;
        end
      end
      LEN_LO: begin
        if (acc) begin
          len_d = frame_len;
          if (32'(frame_len) > AVAIL) begin
            state_d = FAIL;
          end else if (frame_len == 16'd0) begin
            state_d = CSUM;
          end else begin
            state_d = LOAD;
          end
        end
      end
      LOAD: begin
        if (acc) begin
          count_d = count_q + 16'd1;
          sum_d   = sum_q + ld_data;
          if (count_q == len_q - 16'd1) begin
            state_d = CSUM;
          end
        end
      end
      CSUM: begin
        if (acc) begin
          hold_d  = '0;
          state_d = (ld_data == sum_q) ? RELEASE : FAIL;
        end
      end
      RELEASE: begin
        if (hold_q == 8'(RST_HOLD - 1)) begin
          state_d = RUN;
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end
      RUN, FAIL: begin
        if (reload) begin
          state_d = LEN_HI;
          count_d = '0;
          sum_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered handshake and CPU reset follow the state being entered.
  always_comb begin
    ld_ready_d = (state_d == LEN_HI) || (state_d == LEN_LO) ||
                 (state_d == LOAD)   || (state_d == CSUM);
    cpu_rst_d  = (state_d != RUN);
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ld_ready_q <= 1'b0;
      cpu_rst_q  <= 1'b1;
      len_hi_q   <= '0;
      len_q      <= '0;
      count_q    <= '0;
      sum_q      <= '0;
      hold_q     <= '0;
    end else begin
      state_q    <= state_d;
      ld_ready_q <= ld_ready_d;
      cpu_rst_q  <= cpu_rst_d;
      len_hi_q   <= len_hi_d;
      len_q      <= len_d;
      count_q    <= count_d;
      sum_q      <= sum_d;
      hold_q     <= hold_d;
    end
  end

  boot_bus_mux #(
    .ADDR_W(ADDR_W)
  ) u_bus_mux (
    .run_sel  (state_q == RUN),
    .ld_addr  (ld_addr),
    .ld_di    (ld_data),
    .ld_we    (ld_we),
    .cpu_addr (cpu_addr),
    .cpu_do   (cpu_do),
    .cpu_we   (cpu_we),
    .ram_addr (ram_addr),
    .ram_di   (ram_di),
    .ram_we   (ram_we)
  );

endmodule

// File: tb/tb_boot_loader.sv
// Directed testbench for boot_loader with a RAM model and a write scoreboard.
module tb_boot_loader;

  localparam int RST_HOLD = 4;
  localparam int MEM_SIZE = 256;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  ld_data;
  logic        ld_valid;
  logic        ld_ready;
  logic        reload;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_do;
  logic        cpu_we;
  logic [15:0] ram_addr;
  logic [7:0]  ram_di;
  logic        ram_we;
  logic        cpu_rst;
  logic        busy;
  logic        done;
  logic        err;

  int pass_count = 0;
  int check_count = 0;

  logic [7:0]  ram_model [0:MEM_SIZE-1];
  logic [23:0] exp_q [$];
  logic [7:0]  frame_q [$];

  boot_loader #(
    .ADDR_W    (16),
    .BASE_ADDR (16'h0000),
    .MEM_SIZE  (MEM_SIZE),
    .RST_HOLD  (RST_HOLD)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ld_data  (ld_data),
    .ld_valid (ld_valid),
    .ld_ready (ld_ready),
    .reload   (reload),
    .cpu_addr (cpu_addr),
    .cpu_do   (cpu_do),
    .cpu_we   (cpu_we),
    .ram_addr (ram_addr),
    .ram_di   (ram_di),
    .ram_we   (ram_we),
    .cpu_rst  (cpu_rst),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  // Free-running system clock.
  always #5 clk = ~clk;

  // Single-port RAM model written from the DUT's RAM bus.
  always @(posedge clk) begin
    if (ram_we === 1'b1) ram_model[ram_addr[7:0]] <= ram_di;
  end

  // Every RAM write must match the oldest expected write; any unexpected write fails.
  always @(negedge clk) begin
    if (ram_we === 1'b1) begin
      check_count++;
      if (exp_q.size() == 0) begin
        assert (1'b0) else
          $error("[TB] FAIL unexpected_ram_we: got addr %0h data %0h, required no write", ram_addr, ram_di);
      end else begin
        logic [23:0] e;
        e = exp_q.pop_front();
        assert ({ram_addr, ram_di} === e) pass_count++;
        else $error("[TB] FAIL ram_write: got %0h/%0h, required %0h/%0h", ram_addr, ram_di, e[23:8], e[7:0]);
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    check_count++;
    assert (obs === expv) pass_count++;
    else $error("[TB] FAIL %s: got %0h, required %0h", tag, obs, expv);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one byte and hold it until accepted; a bounded wait guards against a stuck ld_ready.
  task automatic sendByte(input logic [7:0] b);
    bit got = 0;
    ld_data  = b;
    ld_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (ld_ready === 1'b1) begin
        got = 1;
        break;
      end
    end
    if (!got) checkOutput("ld_ready_timeout", 32'd0, 32'd1);
    tick();
    ld_valid = 1'b0;
  endtask

  // Send the first nsend bytes of frame_q, recording the RAM writes the payload should cause.
  task automatic applyStimulus(input int nsend, input bit gap);
    int n;
    n = {frame_q[0], frame_q[1]};
    for (int i = 0; i < nsend; i++) begin
      if (i >= 2 && i < 2 + n && n <= MEM_SIZE) exp_q.push_back({16'(i - 2), frame_q[i]});
      sendByte(frame_q[i]);
      if (gap) tick();
    end
  endtask

  task automatic waitDone(input string tag);
    for (int k = 0; k < 20; k++) begin
      if (done === 1'b1) break;
      tick();
    end
    checkOutput(tag, done, 1'b1);
  endtask

  task automatic pulseReload();
    reload = 1'b1;
    tick();
    reload = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < MEM_SIZE; i++) ram_model[i] = 8'h00;
    rst = 1'b1; ld_data = '0; ld_valid = 1'b0; reload = 1'b0;
    cpu_addr = '0; cpu_do = '0; cpu_we = 1'b0;
    tick();
    checkOutput("rst_ld_ready", ld_ready, 1'b0);
    checkOutput("rst_cpu_rst", cpu_rst, 1'b1);
    checkOutput("rst_busy", busy, 1'b1);
    checkOutput("rst_done", done, 1'b0);
    checkOutput("rst_err", err, 1'b0);
    rst = 1'b0;

    // Continuous stream 00 03 AA BB CC 31 and exact CPU reset release timing.
    frame_q = '{8'h00, 8'h03, 8'hAA, 8'hBB, 8'hCC, 8'h31};
    applyStimulus(6, 1'b0);
    checkOutput("t1_ld_ready_release", ld_ready, 1'b0);
    for (int c = 1; c < RST_HOLD; c++) begin
      tick();
      checkOutput("t1_cpu_rst_hold", cpu_rst, 1'b1);
    end
    tick();
    checkOutput("t1_cpu_rst_fall", cpu_rst, 1'b0);
    checkOutput("t1_done", done, 1'b1);
    checkOutput("t1_err", err, 1'b0);
    checkOutput("t1_busy", busy, 1'b0);
    checkOutput("t1_ram0", ram_model[0], 8'hAA);
    checkOutput("t1_ram1", ram_model[1], 8'hBB);
    checkOutput("t1_ram2", ram_model[2], 8'hCC);

    // CPU write in RUN, then reload and a one-byte frame.
    cpu_addr = 16'd100; cpu_do = 8'd55; cpu_we = 1'b1;
    exp_q.push_back({16'd100, 8'd55});
    tick();
    cpu_we = 1'b0;
    checkOutput("t5_ram100", ram_model[100], 8'd55);
    pulseReload();
    checkOutput("t5_reload_cpu_rst", cpu_rst, 1'b1);
    checkOutput("t5_reload_done", done, 1'b0);
    checkOutput("t5_reload_ld_ready", ld_ready, 1'b1);
    frame_q = '{8'h00, 8'h01, 8'h07, 8'h07};
    applyStimulus(4, 1'b0);
    waitDone("t5_done");
    checkOutput("t5_ram0", ram_model[0], 8'h07);

    // Same three-byte frame with a gap cycle after every byte.
    pulseReload();
    frame_q = '{8'h00, 8'h03, 8'hAA, 8'hBB, 8'hCC, 8'h31};
    applyStimulus(6, 1'b1);
    waitDone("t2_done");
    checkOutput("t2_err", err, 1'b0);
    checkOutput("t2_ram0", ram_model[0], 8'hAA);
    checkOutput("t2_ram1", ram_model[1], 8'hBB);
    checkOutput("t2_ram2", ram_model[2], 8'hCC);

    // Bad checksum: FAIL holds the CPU and blocks CPU writes.
    pulseReload();
    frame_q = '{8'h00, 8'h02, 8'h10, 8'h20, 8'h00};
    applyStimulus(5, 1'b0);
    checkOutput("t3_err", err, 1'b1);
    checkOutput("t3_cpu_rst", cpu_rst, 1'b1);
    checkOutput("t3_ld_ready", ld_ready, 1'b0);
    checkOutput("t3_busy", busy, 1'b0);
    cpu_addr = 16'd5; cpu_do = 8'h99; cpu_we = 1'b1;
    @(negedge clk);
    checkOutput("t3_ram_we_blocked", ram_we, 1'b0);
    tick();
    cpu_we = 1'b0;
    checkOutput("t3_ram5", ram_model[5], 8'h00);
    pulseReload();
    checkOutput("t3_reload_err", err, 1'b0);
    checkOutput("t3_reload_ld_ready", ld_ready, 1'b1);

    // Oversized length 0x0101 against a 256-byte RAM fails right after the header.
    frame_q = '{8'h01, 8'h01};
    applyStimulus(2, 1'b0);
    checkOutput("t4_err", err, 1'b1);
    checkOutput("t4_ld_ready", ld_ready, 1'b0);
    checkOutput("t4_ram_we", ram_we, 1'b0);
    pulseReload();
    checkOutput("t4_reload_err", err, 1'b0);
    checkOutput("t4_reload_ld_ready", ld_ready, 1'b1);
    checkOutput("t4_reload_cpu_rst", cpu_rst, 1'b1);

    // Asynchronous reset two payload bytes into a five-byte frame, then a fresh load.
    frame_q = '{8'h00, 8'h05, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h0F};
    applyStimulus(4, 1'b0);
    rst = 1'b1;
    #1;
    checkOutput("t6_rst_ld_ready", ld_ready, 1'b0);
    checkOutput("t6_rst_cpu_rst", cpu_rst, 1'b1);
    checkOutput("t6_rst_busy", busy, 1'b1);
    checkOutput("t6_rst_done", done, 1'b0);
    checkOutput("t6_rst_err", err, 1'b0);
    checkOutput("t6_ram0_kept", ram_model[0], 8'h01);
    checkOutput("t6_ram1_kept", ram_model[1], 8'h02);
    tick();
    rst = 1'b0;
    frame_q = '{8'h00, 8'h02, 8'h5A, 8'hA5, 8'hFF};
    applyStimulus(5, 1'b0);
    waitDone("t6_done");
    checkOutput("t6_err", err, 1'b0);
    checkOutput("t6_ram0", ram_model[0], 8'h5A);
    checkOutput("t6_ram1", ram_model[1], 8'hA5);

    tick();
    checkOutput("scoreboard_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
